seg_scan_sched: RTL and testbench

Scan scheduler and source arbiter for the board's 4-digit multiplexed seven-segment display. It time-slices the shared segment bus across the four digits and inserts a blanking gap at each digit switch to suppress ghosting. It also arbitrates between the always-present primary source (counter values) and a one-shot overlay source (status/message codes) that takes the display for a fixed number of frames. It sits between the counter/status logic and the display pins, replacing ad-hoc per-design scan code.

---
 rtl/seg_scan_sched.sv | 148 ++++++++++++++
 tb/tb_seg_scan_sched.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_sched.sv
// Scan scheduler and source arbiter for a 4-digit multiplexed seven-segment display.
// Build option: define SEG_OVL_PREEMPT_EN to let a new overlay request replace an active overlay.
module seg_scan_sched #(
    parameter int SCAN_DIV    = 200,
    parameter int BLANK_CYC   = 4,
    parameter int HOLD_FRAMES = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pri_data,
    input  logic [3:0]  pri_en,
    input  logic        ovl_req,
    input  logic [15:0] ovl_data,
    output logic        ovl_ack,
    output logic        ovl_busy,
    output logic [3:0]  control,
    output logic [7:0]  display,
    output logic        frame_tick
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int HW = $clog2(HOLD_FRAMES + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYC);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_FRAMES);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

    typedef enum logic {PRI, OVL} src_t;

    function automatic logic [7:0] seg_decode(input logic [3:0] code);
        case (code)
            4'h0: seg_decode = 8'hFC;
            4'h1: seg_decode = 8'h60;
            4'h2: seg_decode = 8'hDA;
            4'h3: seg_decode = 8'hF2;
            4'h4: seg_decode = 8'h66;
            4'h5: seg_decode = 8'hB6;
            4'h6: seg_decode = 8'hBE;
            4'h7: seg_decode = 8'hE0;
            4'h8: seg_decode = 8'hFE;
            4'h9: seg_decode = 8'hF6;
            4'hA: seg_decode = 8'hEE;
            4'hB: seg_decode = 8'h3E;
            4'hC: seg_decode = 8'h9C;
            4'hD: seg_decode = 8'h7A;
            4'hE: seg_decode = 8'h9E;
            default: seg_decode = 8'h8E;
        endcase
    endfunction

    logic [SW-1:0] slot_cnt, slot_nxt;
    logic [1:0]    digit, digit_nxt;
    logic [15:0]   snap_data, snap_data_nxt;
    logic [3:0]    snap_en, snap_en_nxt;
    logic [15:0]   ovl_buf, ovl_buf_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    src_t          state, state_nxt;
    logic          tick_now, accept;
    logic [3:0]    control_nxt;
    logic [7:0]    display_nxt;
    logic          frame_tick_nxt;

    // Outputs are computed from next-state values so each registered output lines up
    // with the scan position held in slot_cnt/digit during the same cycle.
    // NOTE: every signal gets a default before any branch, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        slot_nxt      = slot_cnt + SW'(1);
        digit_nxt     = digit;
        snap_data_nxt = snap_data;
        snap_en_nxt   = snap_en;
        state_nxt     = state;
        hold_nxt      = hold_cnt;
        ovl_buf_nxt   = ovl_buf;
        control_nxt   = 4'b1111;
        display_nxt   = 8'h00;

        tick_now = (slot_cnt == SLOT_LAST) && (digit == 2'd3);
        if (slot_cnt == SLOT_LAST) begin
            slot_nxt  = '0;
            digit_nxt = digit + 2'd1;
        end

        // Snapshot source follows the state before the edge, so the last overlay frame still loads ovl_buf.
        if (tick_now) begin
            if (state == OVL) begin
                snap_data_nxt = ovl_buf;
                snap_en_nxt   = 4'hF;
            end else begin
                snap_data_nxt = pri_data;
                snap_en_nxt   = pri_en;
            end
        end

`ifdef SEG_OVL_PREEMPT_EN
        // The ack cycle is masked so a requester still holding req then is not accepted twice.
        accept = ovl_req && !ovl_ack;
`else
        accept = ovl_req && (state == PRI);
`endif

        if (accept) begin
            state_nxt   = OVL;
            hold_nxt    = HOLD_INIT;
            ovl_buf_nxt = ovl_data;
        end else if ((state == OVL) && tick_now) begin
            if (hold_cnt == HOLD_ONE)
                state_nxt = PRI;
            hold_nxt = hold_cnt - HOLD_ONE;
        end

        if ((slot_nxt >= BLANK_END) && snap_en_nxt[digit_nxt]) begin
            control_nxt = ~(4'b1000 >> digit_nxt);
            display_nxt = seg_decode(snap_data_nxt[{digit_nxt, 2'b00} +: 4]);
        end

        frame_tick_nxt = (slot_nxt == SLOT_LAST) && (digit_nxt == 2'd3);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_cnt   <= '0;
            digit      <= 2'd0;
            snap_data  <= 16'h0000;
            snap_en    <= 4'hF;
            ovl_buf    <= 16'h0000;
            hold_cnt   <= '0;
            state      <= PRI;
            ovl_ack    <= 1'b0;
            ovl_busy   <= 1'b0;
            control    <= 4'b1111;
            display    <= 8'h00;
            frame_tick <= 1'b0;
        end else begin
            slot_cnt   <= slot_nxt;
            digit      <= digit_nxt;
            snap_data  <= snap_data_nxt;
            snap_en    <= snap_en_nxt;
            ovl_buf    <= ovl_buf_nxt;
            hold_cnt   <= hold_nxt;
            state      <= state_nxt;
            ovl_ack    <= accept;
            ovl_busy   <= (state_nxt == OVL);
            control    <= control_nxt;
            display    <= display_nxt;
            frame_tick <= frame_tick_nxt;
        end
    end
endmodule

// File: tb/tb_seg_scan_sched.sv
// Self-checking bench for seg_scan_sched: per-frame expectations queued when stimulus is driven,
// checked cycle by cycle as the frame is scanned out. Follows SEG_OVL_PREEMPT_EN like the design.
module tb_seg_scan_sched;
    localparam int FRAME = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pri_data;
    logic [3:0]  pri_en;
    logic        ovl_req;
    logic [15:0] ovl_data;
    logic        ovl_ack;
    logic        ovl_busy;
    logic [3:0]  control;
    logic [7:0]  display;
    logic        frame_tick;

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  en;
    } frame_t;

    frame_t frame_q[$];
    frame_t cur;
    logic   cur_valid = 1'b0;
    logic   mon_en = 1'b0;
    int     cyc = -1;
    int     n_checks = 0;
    int     n_pass = 0;
    int     ack_cyc;
    int     s_base;

    logic [7:0] seg_ref [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                 8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};
    logic [3:0] ctl_ref [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    seg_scan_sched #(.SCAN_DIV(8), .BLANK_CYC(2), .HOLD_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .pri_data(pri_data), .pri_en(pri_en),
        .ovl_req(ovl_req), .ovl_data(ovl_data), .ovl_ack(ovl_ack), .ovl_busy(ovl_busy),
        .control(control), .display(display), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    endtask

    task automatic push_frame(input logic [15:0] data, input logic [3:0] en);
        frame_t f;
        f.data = data;
        f.en   = en;
        frame_q.push_back(f);
    endtask

    // Compare the outputs of the current cycle against the frame expected in this slot position.
    task automatic monitor();
        int pos, dig, sub;
        logic [3:0] exp_ctl;
        logic [7:0] exp_disp;
        logic [3:0] nib;
        pos = cyc % FRAME;
        dig = pos / 8;
        sub = pos % 8;
        if (pos == 0) begin
            check("sb_has_frame", 32'(frame_q.size() != 0), 32'd1);
            cur_valid = (frame_q.size() != 0);
            if (cur_valid) cur = frame_q.pop_front();
        end
        check("frame_tick", 32'(frame_tick), 32'(pos == FRAME - 1));
        if (cur_valid) begin
            exp_ctl  = 4'b1111;
            exp_disp = 8'h00;
            if (sub >= 2 && cur.en[dig]) begin
                nib      = cur.data[dig*4 +: 4];
                exp_ctl  = ctl_ref[dig];
                exp_disp = seg_ref[nib];
            end
            check($sformatf("control d%0d s%0d", dig, sub), 32'(control), 32'(exp_ctl));
            check($sformatf("display d%0d s%0d", dig, sub), 32'(display), 32'(exp_disp));
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        if (mon_en) monitor();
    endtask

    task automatic run_to(input int n);
        while (cyc < n) cycle();
    endtask

    // Step until ovl_ack is seen; ack_cyc is -1 if the budget runs out.
    task automatic wait_ack(input int budget);
        ack_cyc = -1;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (ovl_ack === 1'b1) begin
                ack_cyc = cyc;
                break;
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        pri_data = 16'h0000;
        pri_en   = 4'h0;
        ovl_req  = 1'b0;
        ovl_data = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst control", 32'(control), 32'hF);
        check("rst display", 32'(display), 32'h00);
        check("rst ack", 32'(ovl_ack), 32'd0);
        check("rst busy", 32'(ovl_busy), 32'd0);
        check("rst tick", 32'(frame_tick), 32'd0);

        @(posedge clk);
        #1 reset = 1'b0;
        cyc    = -1;
        mon_en = 1'b1;
        push_frame(16'h0000, 4'hF);
        pri_data = 16'h1234;
        pri_en   = 4'hF;
        push_frame(16'h1234, 4'hF);
        push_frame(16'h1234, 4'hF);

        // Digit 2 disabled for one frame.
        run_to(95);
        pri_en = 4'b1011;
        push_frame(16'h1234, 4'b1011);

        // Mid-frame data change must not tear the current frame.
        run_to(106);
        pri_data = 16'h5678;
        pri_en   = 4'hF;
        push_frame(16'h5678, 4'hF);

        // First overlay, requested mid-frame; primary enables dropped to show they are ignored.
        run_to(140);
        ovl_req  = 1'b1;
        ovl_data = 16'hFFFF;
        cycle();
        check("ovl1 ack", 32'(ovl_ack), 32'd1);
        check("ovl1 busy", 32'(ovl_busy), 32'd1);
        ovl_req  = 1'b0;
        ovl_data = 16'h0000;
        pri_en   = 4'h0;
        push_frame(16'hFFFF, 4'hF);
        push_frame(16'hFFFF, 4'hF);
        cycle();
        check("ovl1 ack pulse", 32'(ovl_ack), 32'd0);
        check("ovl1 busy hold", 32'(ovl_busy), 32'd1);
        run_to(191);
        check("ovl1 busy last", 32'(ovl_busy), 32'd1);
        cycle();
        check("ovl1 busy drop", 32'(ovl_busy), 32'd0);
        pri_en = 4'hF;
        push_frame(16'h5678, 4'hF);

        // Second overlay, then a competing request while it is active.
        run_to(229);
        ovl_req  = 1'b1;
        ovl_data = 16'h3333;
        wait_ack(64);
        check("ovl2 ack cycle", 32'(ack_cyc), 32'd230);
        ovl_req  = 1'b0;
        ovl_data = 16'h0000;
        push_frame(16'h3333, 4'hF);

        run_to(261);
        ovl_req  = 1'b1;
        ovl_data = 16'hAAAA;
`ifdef SEG_OVL_PREEMPT_EN
        push_frame(16'hAAAA, 4'hF);
        push_frame(16'hAAAA, 4'hF);
        push_frame(16'h5678, 4'hF);
        wait_ack(64);
        check("ovl3 ack cycle", 32'(ack_cyc), 32'd262);
        ovl_req  = 1'b0;
        ovl_data = 16'h0000;
        run_to(319);
        check("ovl3 busy last", 32'(ovl_busy), 32'd1);
        cycle();
        check("ovl3 busy drop", 32'(ovl_busy), 32'd0);
        s_base = 352;
`else
        push_frame(16'h3333, 4'hF);
        push_frame(16'hAAAA, 4'hF);
        push_frame(16'hAAAA, 4'hF);
        push_frame(16'h5678, 4'hF);
        wait_ack(64);
        check("ovl3 ack cycle", 32'(ack_cyc), 32'd289);
        ovl_req  = 1'b0;
        ovl_data = 16'h0000;
        run_to(351);
        check("ovl3 busy last", 32'(ovl_busy), 32'd1);
        cycle();
        check("ovl3 busy drop", 32'(ovl_busy), 32'd0);
        s_base = 384;
`endif

        // Reset while an overlay frame is on the display.
        run_to(s_base + 2);
        ovl_req  = 1'b1;
        ovl_data = 16'h1111;
        wait_ack(64);
        check("ovl4 ack cycle", 32'(ack_cyc), 32'(s_base + 3));
        ovl_req  = 1'b0;
        ovl_data = 16'h0000;
        push_frame(16'h1111, 4'hF);
        run_to(s_base + FRAME + 12);
        check("ovl4 busy", 32'(ovl_busy), 32'd1);
        reset  = 1'b1;
        mon_en = 1'b0;
        cycle();
        check("mid rst control", 32'(control), 32'hF);
        check("mid rst display", 32'(display), 32'h00);
        check("mid rst ack", 32'(ovl_ack), 32'd0);
        check("mid rst busy", 32'(ovl_busy), 32'd0);
        check("mid rst tick", 32'(frame_tick), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc = -1;
        frame_q.delete();
        mon_en = 1'b1;
        push_frame(16'h0000, 4'hF);
        push_frame(16'h5678, 4'hF);
        run_to(2 * FRAME - 1);
        check("post rst busy", 32'(ovl_busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
